// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared AXI4-Lite response codes and CSR bank FSM state types.
// Used by axi4_lite_csr_wr_ctrl and axi4_lite_csr_bank.
package axi4_lite_pkg;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_COMMIT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bundle (AW, W, B, AR, R channels).
// Modports: master (drives requests) and slave (drives responses).
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_csr_wr_ctrl.sv
// axi4_lite_csr_wr_ctrl: AW/W capture, write FSM and B response for the CSR bank.
// Ports:
//   aclk, areset                      clock, async active-high reset
//   awaddr/awvalid/awready            AW channel
//   wdata/wstrb/wvalid/wready         W channel
//   bresp/bvalid/bready               B channel
//   commit                            one-cycle strobe: apply held write at next edge
//   cmt_idx/cmt_data/cmt_strb         held word index, data and byte strobes
module axi4_lite_csr_wr_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter int         DATA_WIDTH = 32,
  parameter int         REG_CNT    = 16,
  parameter logic [1:0] OOR_RESP   = AXI4_RESP_OKAY
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   cmt_idx,
  output logic [DATA_WIDTH-1:0]   cmt_data,
  output logic [DATA_WIDTH/8-1:0] cmt_strb
);
  localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);

  wr_state_e             state, state_next;
  logic                  aw_held, w_held, aw_held_d, w_held_d;
  logic                  awready_d, wready_d, bvalid_d;
  logic [1:0]            bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic                  aw_hs, w_hs, oor;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign cmt_idx  = awaddr_q >> ADDR_LSB;
  assign oor      = cmt_idx >= ADDR_WIDTH'(REG_CNT);
  // Registers are written on the edge that enters WR_COMMIT, so ctrl_o
  // changes and ctrl_wr_o pulses during the COMMIT cycle itself.
  assign commit   = (state == WR_IDLE) & aw_held & w_held;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= WR_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WR_IDLE:   if (aw_held && w_held) state_next = WR_COMMIT;
      WR_COMMIT: state_next = WR_RESP;
      WR_RESP:   if (bready) state_next = WR_IDLE;
      default:   state_next = WR_IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    aw_held_d = (state == WR_IDLE) ? (aw_held | aw_hs) : 1'b0;
    w_held_d  = (state == WR_IDLE) ? (w_held  | w_hs)  : 1'b0;
    awready_d = (state_next == WR_IDLE) & ~aw_held_d;
    wready_d  = (state_next == WR_IDLE) & ~w_held_d;
    bvalid_d  = (state_next == WR_RESP);
    bresp_d   = bresp;
    if (state == WR_COMMIT) bresp_d = oor ? OOR_RESP : AXI4_RESP_OKAY;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= AXI4_RESP_OKAY;
      awaddr_q <= '0;
      cmt_data <= '0;
      cmt_strb <= '0;
    end else begin
      aw_held <= aw_held_d;
      w_held  <= w_held_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
        cmt_data <= wdata;
        cmt_strb <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_csr_bank.sv
// axi4_lite_csr_bank: AXI4-Lite slave CSR bank with RW control and RO status registers.
// Ports:
//   aclk, areset   clock, async active-high reset
//   csr_if         AXI4-Lite slave port (awprot/arprot ignored)
//   ctrl_o         RW register contents, word indices 0..RW_CNT-1
//   ctrl_wr_o      per-register one-cycle pulse on a committed write
//   status_i       RO register values, word indices RW_CNT..RW_CNT+RO_CNT-1
// Build option: AXI4_LITE_CSR_SLVERR_EN -- out-of-range accesses answer SLVERR
// instead of OKAY.
module axi4_lite_csr_bank
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RW_CNT     = 8,
  parameter int RO_CNT     = 8
) (
  input  logic                               aclk,
  input  logic                               areset,
  axi4_lite_if.slave                         csr_if,
  output logic [RW_CNT-1:0][DATA_WIDTH-1:0]  ctrl_o,
  output logic [RW_CNT-1:0]                  ctrl_wr_o,
  input  logic [RO_CNT-1:0][DATA_WIDTH-1:0]  status_i
);
  localparam int STRB_W   = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int REG_CNT  = RW_CNT + RO_CNT;
`ifdef AXI4_LITE_CSR_SLVERR_EN
  localparam logic [1:0] OOR_RESP = AXI4_RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = AXI4_RESP_OKAY;
`endif

  // ---------------- write channel ----------------
  logic                  commit;
  logic [ADDR_WIDTH-1:0] cmt_idx;
  logic [DATA_WIDTH-1:0] cmt_data;
  logic [STRB_W-1:0]     cmt_strb;

  axi4_lite_csr_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_CNT    (REG_CNT),
    .OOR_RESP   (OOR_RESP)
  ) u_wr_ctrl (
    .aclk     (aclk),
    .areset   (areset),
    .awaddr   (csr_if.awaddr),
    .awvalid  (csr_if.awvalid),
    .awready  (csr_if.awready),
    .wdata    (csr_if.wdata),
    .wstrb    (csr_if.wstrb),
    .wvalid   (csr_if.wvalid),
    .wready   (csr_if.wready),
    .bresp    (csr_if.bresp),
    .bvalid   (csr_if.bvalid),
    .bready   (csr_if.bready),
    .commit   (commit),
    .cmt_idx  (cmt_idx),
    .cmt_data (cmt_data),
    .cmt_strb (cmt_strb)
  );

  // ---------------- RW bank ----------------
  // RO and out-of-range indices match no entry, so those writes drop
  // silently with no pulse.
  logic [RW_CNT-1:0][DATA_WIDTH-1:0] ctrl_q;
  logic [RW_CNT-1:0]                 ctrl_wr_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ctrl_q    <= '0;
      ctrl_wr_q <= '0;
    end else begin
      ctrl_wr_q <= '0;
      for (int i = 0; i < RW_CNT; i++) begin
        if (commit && cmt_idx == ADDR_WIDTH'(i)) begin
          ctrl_wr_q[i] <= 1'b1;
          for (int b = 0; b < STRB_W; b++)
            if (cmt_strb[b]) ctrl_q[i][b*8 +: 8] <= cmt_data[b*8 +: 8];
        end
      end
    end
  end

  assign ctrl_o    = ctrl_q;
  assign ctrl_wr_o = ctrl_wr_q;

  // ---------------- read channel ----------------
  rd_state_e             rd_state, rd_next;
  logic                  arready_q, rvalid_q, arready_d, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] ar_idx;
  logic                  ar_hs;

  assign ar_idx = csr_if.araddr >> ADDR_LSB;
  assign ar_hs  = csr_if.arvalid & arready_q;

  // Read mux; out-of-range falls through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < RW_CNT; i++)
      if (ar_idx == ADDR_WIDTH'(i)) rd_mux = ctrl_q[i];
    for (int i = 0; i < RO_CNT; i++)
      if (ar_idx == ADDR_WIDTH'(RW_CNT + i)) rd_mux = status_i[i];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) rd_state <= RD_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (csr_if.rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    arready_d = (rd_next == RD_IDLE);
    rvalid_d  = (rd_next == RD_RESP);
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs) begin
      rdata_d = rd_mux;
      rresp_d = (ar_idx >= ADDR_WIDTH'(REG_CNT)) ? OOR_RESP : AXI4_RESP_OKAY;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI4_RESP_OKAY;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign csr_if.arready = arready_q;
  assign csr_if.rvalid  = rvalid_q;
  assign csr_if.rdata   = rdata_q;
  assign csr_if.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_csr_bank.sv
// tb_axi4_lite_csr_bank: scoreboard bench for axi4_lite_csr_bank (8 RW, 8 RO, 32-bit).
module tb_axi4_lite_csr_bank;
  import axi4_lite_pkg::*;

  localparam int AW = 16, DW = 32, NRW = 8, NRO = 8;
`ifdef AXI4_LITE_CSR_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    string         tag;
  } rsp_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [NRW-1:0][DW-1:0] ctrl_o;
  logic [NRW-1:0]         ctrl_wr_o;
  logic [NRO-1:0][DW-1:0] status;

  axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_csr_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_CNT(NRW), .RO_CNT(NRO)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .csr_if    (bus),
    .ctrl_o    (ctrl_o),
    .ctrl_wr_o (ctrl_wr_o),
    .status_i  (status)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] model [NRW];
  rsp_t rq[$], bq[$];
  rsp_t mon_r;
  int pulses [NRW];
  int pulse_tot = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pulse counting and response scoreboards (sampled at negedge).
  always @(negedge aclk) begin
    if (!areset) begin
      for (int i = 0; i < NRW; i++)
        if (ctrl_wr_o[i]) begin pulses[i]++; pulse_tot++; end
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          mon_r = rq.pop_front();
          chk({mon_r.tag, "_rdata"}, bus.rdata, mon_r.data);
          chk({mon_r.tag, "_rresp"}, bus.rresp, mon_r.resp);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          mon_r = bq.pop_front();
          chk({mon_r.tag, "_bresp"}, bus.bresp, mon_r.resp);
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    int idx = int'(a >> 2);
    if (idx < NRW) return model[idx];
    if (idx < NRW + NRO) return status[idx-NRW];
    return '0;
  endfunction

  task automatic drain();
    for (int t = 0; t < 100 && (rq.size() != 0 || bq.size() != 0); t++) @(posedge aclk);
    #1;
    chk("drain", rq.size() + bq.size(), 0);
  endtask

  task automatic chk_ctrl(input string tag);
    for (int i = 0; i < NRW; i++) chk(tag, ctrl_o[i], model[i]);
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input int dly);
    bit hs = 0;
    repeat (dly) @(posedge aclk);
    #1;
    bus.awaddr = a; bus.awvalid = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge aclk); hs = bus.awready;
      @(posedge aclk);
    end
    if (!hs) chk("aw_timeout", 0, 1);
    #1 bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s, input int dly);
    bit hs = 0;
    repeat (dly) @(posedge aclk);
    #1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge aclk); hs = bus.wready;
      @(posedge aclk);
    end
    if (!hs) chk("w_timeout", 0, 1);
    #1 bus.wvalid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input string tag, input bit wait_b);
    rsp_t e;
    int idx = int'(a >> 2);
    if (idx < NRW)
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    e.data = '0; e.resp = (idx >= NRW + NRO) ? OOR : AXI4_RESP_OKAY; e.tag = tag;
    bq.push_back(e);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    if (wait_b) drain();
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag, input bit wait_r);
    bit hs = 0;
    rsp_t e;
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge aclk);
      if (bus.arready) begin
        hs = 1;
        e.data = exp_rd(a);
        e.resp = (int'(a >> 2) >= NRW + NRO) ? OOR : AXI4_RESP_OKAY;
        e.tag  = tag;
        rq.push_back(e);
      end
      @(posedge aclk);
    end
    if (!hs) chk("ar_timeout", 0, 1);
    #1 bus.arvalid = 1'b0;
    if (wait_r) drain();
  endtask

  initial begin
    int p, tot;
    logic [DW-1:0] hold_val;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    for (int i = 0; i < NRO; i++) status[i] = 32'hA0A0_0000 + DW'(i);
    for (int i = 0; i < NRW; i++) begin model[i] = '0; pulses[i] = 0; end

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_ctrl", {63'd0, |ctrl_o}, 0);
    chk("rst_ctrl_wr", ctrl_wr_o, 0);
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("post_rst_awready", bus.awready, 1);
    chk("post_rst_wready", bus.wready, 1);
    chk("post_rst_arready", bus.arready, 1);

    // Same-cycle AW/W full-word write
    p = pulses[2]; tot = pulse_tot;
    wr(16'h0008, 32'hDEADBEEF, 4'hF, 0, 0, "t1_wr", 1);
    chk_ctrl("t1_ctrl");
    chk("t1_pulse_idx", pulses[2] - p, 1);
    chk("t1_pulse_tot", pulse_tot - tot, 1);
    rd(16'h0008, "t1_rd", 1);

    // W three cycles ahead of AW, single byte lane
    wr(16'h0000, 32'h11223344, 4'hF, 0, 0, "t2_init", 1);
    wr(16'h0000, 32'h0000AB00, 4'b0010, 3, 0, "t2_wr", 1);
    chk("t2_reg0", ctrl_o[0], 32'h1122AB44);
    chk_ctrl("t2_ctrl");

    // AW ahead of W, mixed strobe
    wr(16'h0014, 32'hCAFEF00D, 4'b1001, 0, 2, "t3_wr", 1);
    chk_ctrl("t3_ctrl");

    // wstrb = 0: no change, pulse still fires
    wr(16'h000C, 32'h55555555, 4'hF, 0, 0, "t4_init", 1);
    p = pulses[3];
    wr(16'h000C, 32'hFFFFFFFF, 4'h0, 1, 0, "t4_wr", 1);
    chk_ctrl("t4_ctrl");
    chk("t4_pulse", pulses[3] - p, 1);

    // RO read and dropped RO write
    status[0] = 32'h12345678;
    rd(16'h0020, "t5_rd", 1);
    tot = pulse_tot;
    wr(16'h0020, 32'h87654321, 4'hF, 0, 0, "t5_wr", 1);
    chk("t5_pulse_tot", pulse_tot - tot, 0);
    chk_ctrl("t5_ctrl");

    // rready held low: payload and arready stable while status moves
    bus.rready = 1'b0;
    status[1] = 32'hCAFE0001;
    rd(16'h0024, "t6_rd", 0);
    @(posedge aclk); #1;
    hold_val = 32'hCAFE0001;
    for (int c = 0; c < 5; c++) begin
      status[1] = $urandom;
      @(posedge aclk); #1;
      chk("t6_rvalid", bus.rvalid, 1);
      chk("t6_rdata_hold", bus.rdata, hold_val);
      chk("t6_arready", bus.arready, 0);
    end
    bus.rready = 1'b1;
    drain();

    // Out-of-range read and write
    rd(16'h0040, "t7_rd", 1);
    tot = pulse_tot;
    wr(16'h0040, 32'h0BADF00D, 4'hF, 0, 0, "t7_wr", 1);
    chk("t7_pulse_tot", pulse_tot - tot, 0);
    chk_ctrl("t7_ctrl");

    // Random fill, then sweep all indices (incl. out-of-range and unaligned)
    for (int i = 0; i < NRW; i++)
      wr(AW'(i*4), $urandom, 4'(($urandom_range(1, 15))), $urandom_range(0, 2),
         $urandom_range(0, 2), "t8_wr", 1);
    chk_ctrl("t8_ctrl");
    for (int i = 0; i < NRW + NRO + 2; i++) rd(AW'(i*4), "t8_rd", 0);
    rd(16'h000A, "t8_unaligned", 1);

    // Reset while waiting in WR_RESP
    bus.bready = 1'b0;
    wr(16'h0004, 32'h0000_55AA, 4'hF, 0, 0, "t9_wr", 0);
    for (int t = 0; t < 20 && !bus.bvalid; t++) begin @(posedge aclk); #1; end
    chk("t9_bvalid_up", bus.bvalid, 1);
    #2 areset = 1'b1;
    #1;
    chk("t9_bvalid_rst", bus.bvalid, 0);
    bq.delete();
    for (int i = 0; i < NRW; i++) model[i] = '0;
    chk_ctrl("t9_ctrl_rst");
    @(posedge aclk); #1;
    areset = 1'b0;
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    wr(16'h0004, 32'h600D_D00D, 4'hF, 0, 0, "t9_after", 1);
    chk_ctrl("t9_ctrl_after");
    rd(16'h0004, "t9_rd", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
